// File: rtl/mac_array_pkg.sv
// Shared types and constants for the MAC tile array phase sequencer.
package mac_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KLOAD = 3'd1,
    ST_KGAP  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // West-edge instruction carried by a state when its beat is issued.
  function automatic logic [1:0] phase_inst(input state_t s);
    logic [1:0] inst;
    case (s)
      ST_KLOAD: inst = INST_KLOAD;
      ST_EXEC:  inst = INST_EXEC;
      default:  inst = INST_IDLE;
    endcase
    return inst;
  endfunction

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Job request, L0 FIFO and array-edge signals of the MAC array sequencer.
interface mac_array_ctrl_if #(
  parameter int len_bw = 8
);

  logic              start;
  logic              mode;
  logic [len_bw-1:0] exec_len;
  logic              l0_empty;
  logic              l0_rd;
  logic [1:0]        inst_w;
  logic              mode_select;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, exec_len, l0_empty,
    input  l0_rd, inst_w, mode_select, busy, done
  );

  modport slave (
    input  start, mode, exec_len, l0_empty,
    output l0_rd, inst_w, mode_select, busy, done
  );

endinterface

// File: rtl/mac_array_ctrl_phase_cnt.sv
// Loadable down-counter shared by every sequencer phase; saturates at zero.
module phase_cnt #(
  parameter int cnt_w = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [cnt_w-1:0] load_val,
  input  logic             hold,
  output logic             zero,
  output logic             last
);

  localparam logic [cnt_w-1:0] ONE = cnt_w'(1);

  logic [cnt_w-1:0] cnt_r;

  // Reload on phase entry, otherwise count down unless stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (!hold && (cnt_r != '0)) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);
  assign last = (cnt_r == ONE);

endmodule

// File: rtl/mac_array_ctrl.sv
// Phase sequencer for the 2D MAC tile array: kernel load, settle, execute, drain.
module mac_array_ctrl
  import mac_array_pkg::*;
#(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic             clk,
  input  logic             reset,
  mac_array_ctrl_if.slave  bus
);

  localparam int CNT_W = max_int(len_bw, $clog2(row + col + 1));
  localparam logic [CNT_W-1:0] KLOAD_LEN = CNT_W'(col);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(row + col);

  state_t            state_r;
  state_t            next_state_s;
  logic [len_bw-1:0] exec_len_r;
  logic              mode_select_r;
  logic              busy_r;
  logic              done_r;
  logic [1:0]        phase_r;
  logic              issue_s;
  logic              cnt_load_s;
  logic              cnt_hold_s;
  logic              cnt_zero_s;
  logic              cnt_last_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic [CNT_W-1:0]  exec_val_s;

  // A beat goes out only when the registered phase wants one and L0 has data.
  assign issue_s    = (phase_r != INST_IDLE) && !bus.l0_empty;
  assign exec_val_s = (state_r == ST_IDLE) ? CNT_W'(bus.exec_len) : CNT_W'(exec_len_r);

  // Next-state selection and counter stall control.
  always_comb begin
    next_state_s = state_r;
    cnt_hold_s   = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.mode == MODE_OS) begin
            if (bus.exec_len == '0) begin
              next_state_s = ST_DRAIN;
            end else begin
              next_state_s = ST_EXEC;
            end
          end else begin
            next_state_s = ST_KLOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_KLOAD: begin
        cnt_hold_s = !issue_s;
        if ((issue_s && cnt_last_s) || cnt_zero_s) begin
          next_state_s = ST_KGAP;
        end else begin
          next_state_s = ST_KLOAD;
        end
      end
      ST_KGAP: begin
        cnt_hold_s = 1'b0;
        if (cnt_last_s || cnt_zero_s) begin
          if (exec_len_r == '0) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_EXEC;
          end
        end else begin
          next_state_s = ST_KGAP;
        end
      end
      ST_EXEC: begin
        cnt_hold_s = !issue_s;
        if ((issue_s && cnt_last_s) || cnt_zero_s) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_DRAIN: begin
        cnt_hold_s = 1'b0;
        if (cnt_last_s || cnt_zero_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Phase length loaded into the shared counter on every state change.
  always_comb begin
    cnt_val_s  = '0;
    cnt_load_s = (next_state_s != state_r);
    case (next_state_s)
      ST_KLOAD: cnt_val_s = KLOAD_LEN;
      ST_KGAP:  cnt_val_s = KLOAD_LEN;
      ST_EXEC:  cnt_val_s = exec_val_s;
      ST_DRAIN: cnt_val_s = DRAIN_LEN;
      default:  cnt_val_s = '0;
    endcase
  end

  // State and Moore output registers; job parameters latch only on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      exec_len_r    <= '0;
      mode_select_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      phase_r       <= INST_IDLE;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      done_r  <= (next_state_s == ST_DONE);
      phase_r <= phase_inst(next_state_s);
      if ((state_r == ST_IDLE) && bus.start) begin
        exec_len_r    <= bus.exec_len;
        mode_select_r <= bus.mode;
      end else begin
        exec_len_r    <= exec_len_r;
        mode_select_r <= mode_select_r;
      end
    end
  end

  phase_cnt #(
    .cnt_w (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .hold     (cnt_hold_s),
    .zero     (cnt_zero_s),
    .last     (cnt_last_s)
  );

  assign bus.inst_w      = issue_s ? phase_r : INST_IDLE;
  assign bus.l0_rd       = issue_s;
  assign bus.mode_select = mode_select_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: phase-queue model plus directed jobs.
module tb_mac_array_ctrl;

  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int LEN_BW = 8;

  localparam int K_GAP  = 0;
  localparam int K_LOAD = 1;
  localparam int K_EXEC = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int cnt;
  } phase_t;

  logic   clk = 1'b0;
  logic   reset;
  int     checks = 0;
  int     failures = 0;
  phase_t q[$];
  logic   mode_exp = 1'b0;

  mac_array_ctrl_if #(.len_bw(LEN_BW)) bus ();

  mac_array_ctrl #(
    .row    (ROW),
    .col    (COL),
    .len_bw (LEN_BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add_phase(input int kind, input int n);
    phase_t p;
    p.kind = kind;
    p.cnt  = n;
    if (n > 0) q.push_back(p);
  endfunction

  // Model: a job is a list of phases; issue phases consume only non-empty cycles.
  always @(negedge clk) begin : model
    int     e_inst;
    int     e_rd;
    int     e_busy;
    int     e_done;
    logic   issue_kind;
    phase_t h;
    if (!reset) begin
      q.delete();
      mode_exp = 1'b0;
    end else begin
      e_busy = (q.size() > 0) ? 1 : 0;
      e_done = 0;
      e_inst = 0;
      e_rd   = 0;
      issue_kind = 1'b0;
      if (q.size() > 0) begin
        issue_kind = (q[0].kind == K_LOAD) || (q[0].kind == K_EXEC);
        if (q[0].kind == K_DONE) e_done = 1;
        if (issue_kind && !bus.l0_empty) begin
          e_rd   = 1;
          e_inst = (q[0].kind == K_LOAD) ? 1 : 2;
        end
      end
      check("inst_w", int'(bus.inst_w), e_inst);
      check("l0_rd", int'(bus.l0_rd), e_rd);
      check("busy", int'(bus.busy), e_busy);
      check("done", int'(bus.done), e_done);
      check("mode_select", int'(bus.mode_select), int'(mode_exp));
      if (q.size() > 0) begin
        h = q.pop_front();
        if (!(issue_kind && bus.l0_empty)) h.cnt = h.cnt - 1;
        if (h.cnt > 0) q.push_front(h);
      end else if (bus.start) begin
        mode_exp = bus.mode;
        if (bus.mode == 1'b0) begin
          add_phase(K_LOAD, COL);
          add_phase(K_GAP, COL);
        end
        add_phase(K_EXEC, int'(bus.exec_len));
        add_phase(K_GAP, ROW + COL);
        add_phase(K_DONE, 1);
      end
    end
  end

  // Entered and left just after a rising edge; cycle 0 is the start cycle.
  task automatic run_job(input string name, input logic m, input int len,
                         input int stall_at, input int stall_n, input int sa1, input int sa2,
                         input int exp_done, input int exp_rd, input int exp_k,
                         input int exp_e, input int exp_msel);
    int cyc;
    int done_cyc;
    int rd_n;
    int k_n;
    int e_n;
    int msel_n;
    int done_n;
    done_cyc = -1;
    rd_n = 0;
    k_n = 0;
    e_n = 0;
    msel_n = 0;
    done_n = 0;
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.exec_len = LEN_BW'(len);
    bus.l0_empty = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 400) begin
      bus.l0_empty = (cyc >= stall_at) && (cyc < stall_at + stall_n);
      bus.start    = (cyc == sa1) || (cyc == sa2);
      @(negedge clk);
      if (bus.inst_w == 2'b01) k_n++;
      if (bus.inst_w == 2'b10) e_n++;
      if (bus.l0_rd) rd_n++;
      if (bus.mode_select) msel_n++;
      if (bus.done) begin
        done_n++;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start    = 1'b0;
    bus.l0_empty = 1'b0;
    check({name, " done_cycle"}, done_cyc, exp_done);
    check({name, " l0_rd_pulses"}, rd_n, exp_rd);
    check({name, " kload_beats"}, k_n, exp_k);
    check({name, " exec_beats"}, e_n, exp_e);
    check({name, " mode_select_cycles"}, msel_n, exp_msel);
    check({name, " done_pulses"}, done_n, 1);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.exec_len = '0;
    bus.l0_empty = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("por inst_w", int'(bus.inst_w), 0);
    check("por l0_rd", int'(bus.l0_rd), 0);
    check("por busy", int'(bus.busy), 0);
    check("por done", int'(bus.done), 0);
    check("por mode_select", int'(bus.mode_select), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // name, mode, len, stall_at, stall_n, start_again x2, done, rd, kload, exec, msel
    run_job("ws16", 1'b0, 16, 0, 0, 20, 49, 49, 24, 8, 16, 0);
    run_job("os4", 1'b1, 4, 0, 0, -1, -1, 21, 4, 0, 4, 21);
    run_job("ws16_stall", 1'b0, 16, 20, 3, -1, -1, 52, 24, 8, 16, 0);
    run_job("ws0", 1'b0, 0, 0, 0, -1, -1, 33, 8, 8, 0, 0);
    run_job("os0", 1'b1, 0, 0, 0, -1, -1, 17, 0, 0, 0, 17);
    run_job("ws2_kstall", 1'b0, 2, 3, 2, -1, -1, 37, 10, 8, 2, 0);
    run_job("os255", 1'b1, 255, 0, 0, -1, -1, 272, 255, 0, 255, 272);

    // Abandon a WS job in KGAP with an asynchronous reset.
    bus.start    = 1'b1;
    bus.mode     = 1'b0;
    bus.exec_len = 8'd16;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    check("kgap busy before reset", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    check("rst inst_w", int'(bus.inst_w), 0);
    check("rst l0_rd", int'(bus.l0_rd), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst mode_select", int'(bus.mode_select), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_job("ws16_after_rst", 1'b0, 16, 0, 0, -1, -1, 49, 24, 8, 16, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
